// File: rtl/caption_fade_ctrl_if.sv
// Pixel lookup bus between the caption compositor and caption_fade_ctrl.
// master = requester/palette side, slave = caption_fade_ctrl.
interface caption_fade_ctrl_if;
   logic        i_pix_valid;
   logic [3:0]  i_pix_idx;
   logic [3:0]  o_pal_addr;
   logic [23:0] i_pal_color;
   logic        o_pix_valid;
   logic [23:0] o_pix_rgb;
   logic        o_pix_opaque;

   modport master (
      output i_pix_valid, i_pix_idx, i_pal_color,
      input  o_pal_addr, o_pix_valid, o_pix_rgb, o_pix_opaque
   );

   modport slave (
      input  i_pix_valid, i_pix_idx, i_pal_color,
      output o_pal_addr, o_pix_valid, o_pix_rgb, o_pix_opaque
   );
endinterface

// File: rtl/caption_fade_ctrl.sv
// Caption fade sequencer (IDLE->FADE_IN->HOLD->FADE_OUT) plus 2-stage palette scaling pipeline.
// Define CAPTION_AUTO_FADE_OUT_EN to leave HOLD automatically after HOLD_FRAMES frames.
module caption_fade_ctrl #(
   parameter int unsigned FRAMES_PER_STEP = 4,
   parameter int unsigned HOLD_FRAMES     = 120
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic                i_frame_start,
   caption_fade_ctrl_if.slave  pix,
   output logic [4:0]          o_level,
   output logic                o_busy,
   output logic                o_done
);

   localparam logic [4:0]  LevelMax  = 5'd16;
   localparam int unsigned FrameCntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [FrameCntW-1:0] FrameLast = FrameCntW'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {StIdle, StFadeIn, StHold, StFadeOut} state_e;

   state_e               r_state;
   logic [4:0]           r_level;
   logic [FrameCntW-1:0] r_frame_cnt;
   logic                 r_done;

`ifdef CAPTION_AUTO_FADE_OUT_EN
   localparam int unsigned HoldCntW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(HOLD_FRAMES - 1);
   logic [HoldCntW-1:0] r_hold_cnt;
`else
   logic w_unused_hold;
   assign w_unused_hold = (HOLD_FRAMES == 0);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_level     <= '0;
         r_frame_cnt <= '0;
         r_done      <= 1'b0;
`ifdef CAPTION_AUTO_FADE_OUT_EN
         r_hold_cnt  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         // Abort beats a coincident start, and in IDLE it simply keeps us there.
         if (i_abort) begin
            r_state     <= StIdle;
            r_level     <= '0;
            r_frame_cnt <= '0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  if (i_start) begin
                     r_state     <= StFadeIn;
                     r_frame_cnt <= '0;
                  end
               end
               StFadeIn: begin
                  if (i_frame_start) begin
                     if (r_frame_cnt == FrameLast) begin
                        r_frame_cnt <= '0;
                        r_level     <= r_level + 5'd1;
                        if (r_level == LevelMax - 5'd1) begin
                           r_state <= StHold;
`ifdef CAPTION_AUTO_FADE_OUT_EN
                           r_hold_cnt <= '0;
`endif
                        end
                     end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                     end
                  end
               end
               StHold: begin
`ifdef CAPTION_AUTO_FADE_OUT_EN
                  if (i_frame_start) begin
                     if (r_hold_cnt == HoldLast) begin
                        r_state     <= StFadeOut;
                        r_frame_cnt <= '0;
                     end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                     end
                  end
`else
                  if (i_start) begin
                     r_state     <= StFadeOut;
                     r_frame_cnt <= '0;
                  end
`endif
               end
               StFadeOut: begin
                  if (i_frame_start) begin
                     if (r_frame_cnt == FrameLast) begin
                        r_frame_cnt <= '0;
                        r_level     <= r_level - 5'd1;
                        if (r_level == 5'd1) begin
                           r_state <= StIdle;
                           r_done  <= 1'b1;
                        end
                     end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_level = r_level;
   assign o_busy  = (r_state != StIdle);
   assign o_done  = r_done;

   assign pix.o_pal_addr = pix.i_pix_idx;

   logic        r_s1_valid;
   logic        r_s1_zero;
   logic [23:0] r_s1_color;
   logic [4:0]  r_s1_level;
   logic        r_pix_valid;
   logic        r_pix_opaque;
   logic [23:0] r_pix_rgb;
   logic [12:0] w_prod_r, w_prod_g, w_prod_b;
   logic [23:0] w_scaled;

   // ch*level/16; at level 16 bits [11:4] are exactly ch.
   always_comb begin
      w_prod_r = 13'(r_s1_color[23:16]) * 13'(r_s1_level);
      w_prod_g = 13'(r_s1_color[15:8])  * 13'(r_s1_level);
      w_prod_b = 13'(r_s1_color[7:0])   * 13'(r_s1_level);
      w_scaled = {w_prod_r[11:4], w_prod_g[11:4], w_prod_b[11:4]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_zero    <= 1'b0;
         r_s1_color   <= '0;
         r_s1_level   <= '0;
         r_pix_valid  <= 1'b0;
         r_pix_opaque <= 1'b0;
         r_pix_rgb    <= '0;
      end else begin
         r_s1_valid   <= pix.i_pix_valid;
         r_s1_zero    <= (pix.i_pix_idx == 4'd0);
         r_s1_color   <= pix.i_pal_color;
         r_s1_level   <= r_level;
         r_pix_valid  <= r_s1_valid;
         r_pix_opaque <= r_s1_valid & ~r_s1_zero;
         r_pix_rgb    <= (r_s1_valid && !r_s1_zero) ? w_scaled : '0;
      end
   end

   assign pix.o_pix_valid  = r_pix_valid;
   assign pix.o_pix_rgb    = r_pix_rgb;
   assign pix.o_pix_opaque = r_pix_opaque;

endmodule

// File: tb/tb_caption_fade_ctrl.sv
// Directed-sequence bench for caption_fade_ctrl with random pixel traffic and a
// frame-count reference model of the fade level and pixel scaling.
module tb_caption_fade_ctrl;
   localparam int unsigned Fps  = 2;
   localparam int unsigned Hold = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, abort, frame;
   logic [4:0] level;
   logic       busy, done;

   caption_fade_ctrl_if pif ();

   caption_fade_ctrl #(
      .FRAMES_PER_STEP(Fps),
      .HOLD_FRAMES    (Hold)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_abort      (abort),
      .i_frame_start(frame),
      .pix          (pif.slave),
      .o_level      (level),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: phase (0 idle, 1 in, 2 hold, 3 out), frames seen in phase.
   int          m_phase  = 0;
   int          m_frames = 0;
   int          m_lvl    = 0;
   bit          m_done   = 0;
   bit          s1_v     = 0;
   logic [23:0] s1_rgb   = '0;
   bit          s1_op    = 0;
   bit          e_v      = 0;
   logic [23:0] e_rgb    = '0;
   bit          e_op     = 0;
   int          done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] scale(input logic [23:0] c, input int l);
      int r, g, b;
      r = (int'(c[23:16]) * l) / 16;
      g = (int'(c[15:8]) * l) / 16;
      b = (int'(c[7:0]) * l) / 16;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic rand_pix();
      pif.i_pix_valid = 1'($urandom_range(0, 1));
      pif.i_pix_idx   = 4'($urandom_range(0, 15));
      pif.i_pal_color = 24'($urandom);
   endtask

   task automatic tick(input bit st, input bit ab, input bit fr);
      start = st;
      abort = ab;
      frame = fr;
      #1;
      chk("pal_addr", 32'(pif.o_pal_addr), 32'(pif.i_pix_idx));
      @(posedge clk);
      // Pixel leaving S2 is the one that entered S1 a cycle earlier.
      e_v   = s1_v;
      e_rgb = s1_rgb;
      e_op  = s1_op;
      s1_v  = pif.i_pix_valid;
      s1_op = pif.i_pix_valid && (pif.i_pix_idx != 0);
      s1_rgb = s1_op ? scale(pif.i_pal_color, m_lvl) : 24'h0;
      m_done = 0;
      if (ab && m_phase != 0) begin
         m_phase = 0;
         m_lvl   = 0;
      end else if (!ab) begin
         case (m_phase)
            0: if (st) begin m_phase = 1; m_frames = 0; end
            1: if (fr) begin
               m_frames++;
               m_lvl = m_frames / Fps;
               if (m_lvl == 16) begin m_phase = 2; m_frames = 0; end
            end
            2: begin
`ifdef CAPTION_AUTO_FADE_OUT_EN
               if (fr) begin
                  m_frames++;
                  if (m_frames == Hold) begin m_phase = 3; m_frames = 0; end
               end
`else
               if (st) begin m_phase = 3; m_frames = 0; end
`endif
            end
            3: if (fr) begin
               m_frames++;
               m_lvl = 16 - m_frames / Fps;
               if (m_lvl == 0) begin m_phase = 0; m_done = 1; end
            end
            default: m_phase = 0;
         endcase
      end
      #1;
      chk("level", 32'(level), 32'(m_lvl));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("pix_valid", 32'(pif.o_pix_valid), 32'(e_v));
      if (e_v) begin
         chk("pix_rgb", 32'(pif.o_pix_rgb), 32'(e_rgb));
         chk("pix_opaque", 32'(pif.o_pix_opaque), 32'(e_op));
      end
      if (done) done_cnt++;
      start = 0;
      abort = 0;
      frame = 0;
      rand_pix();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) tick(0, 0, 0);
         tick(0, 0, 1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pix_valid", 32'(pif.o_pix_valid), 32'd0);
      chk("rst_pix_rgb", 32'(pif.o_pix_rgb), 32'd0);
      chk("rst_pix_opaque", 32'(pif.o_pix_opaque), 32'd0);
      m_phase = 0; m_lvl = 0; m_frames = 0; m_done = 0;
      s1_v = 0; s1_rgb = '0; s1_op = 0;
      pif.i_pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      start = 0; abort = 0; frame = 0;
      pif.i_pix_valid = 0; pif.i_pix_idx = 0; pif.i_pal_color = 0;
      do_reset();

      // Full fade cycle.
      done_cnt = 0;
      tick(1, 0, 1);
      frames(32);
      chk("t1_level_full", 32'(level), 32'd16);
      chk("t1_busy_hold", 32'(busy), 32'd1);
      frames(2);
      tick(1, 0, 0);
`ifdef CAPTION_AUTO_FADE_OUT_EN
      chk("t1_start_in_hold_ignored", 32'(level), 32'd16);
      frames(1);
`endif
      frames(32);
      chk("t1_level_zero", 32'(level), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);
      chk("t1_done_once", 32'(done_cnt), 32'd1);

      // Scaling at level 8 and 16.
      tick(1, 0, 0);
      frames(16);
      chk("t2_level8", 32'(level), 32'd8);
      pif.i_pix_valid = 1; pif.i_pix_idx = 4'd5; pif.i_pal_color = 24'h80FF10;
      tick(0, 0, 0);
      pif.i_pix_valid = 0;
      tick(0, 0, 0);
      chk("t2_rgb_l8", 32'(pif.o_pix_rgb), 32'h407F08);
      chk("t2_opaque_l8", 32'(pif.o_pix_opaque), 32'd1);
      frames(16);
      pif.i_pix_valid = 1; pif.i_pix_idx = 4'd5; pif.i_pal_color = 24'h80FF10;
      tick(0, 0, 0);
      pif.i_pix_valid = 0;
      tick(0, 0, 0);
      chk("t2_rgb_l16", 32'(pif.o_pix_rgb), 32'h80FF10);

      // Back-to-back transparent pixels.
      for (int i = 0; i < 6; i++) begin
         pif.i_pix_valid = 1; pif.i_pix_idx = 4'd0; pif.i_pal_color = 24'($urandom);
         tick(0, 0, 0);
         if (i >= 2) begin
            chk("t3_valid_b2b", 32'(pif.o_pix_valid), 32'd1);
            chk("t3_transparent_rgb", 32'(pif.o_pix_rgb), 32'd0);
         end
      end
      tick(0, 1, 0);

      // Abort with simultaneous start at level 5.
      done_cnt = 0;
      tick(1, 0, 0);
      frames(10);
      chk("t4_level5", 32'(level), 32'd5);
      tick(1, 1, 0);
      chk("t4_abort_level", 32'(level), 32'd0);
      chk("t4_abort_idle", 32'(busy), 32'd0);
      frames(4);

      // Start during fade-in is ignored.
      tick(1, 0, 0);
      frames(3);
      tick(1, 0, 0);
      frames(3);
      chk("t5_level3", 32'(level), 32'd3);
      tick(0, 1, 0);
      chk("t5_abort_idle", 32'(busy), 32'd0);
      chk("t4_t5_no_done", 32'(done_cnt), 32'd0);

      // Reset mid fade-out with pixels in flight.
      tick(1, 0, 0);
      frames(32);
`ifdef CAPTION_AUTO_FADE_OUT_EN
      frames(3);
`else
      tick(1, 0, 0);
`endif
      frames(6);
      chk("t6_level13", 32'(level), 32'd13);
      pif.i_pix_valid = 1; pif.i_pix_idx = 4'd9;
      tick(0, 0, 0);
      pif.i_pix_valid = 1; pif.i_pix_idx = 4'd3;
      tick(0, 0, 0);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         pif.i_pix_valid = 0;
         tick(0, 0, 0);
      end
      pif.i_pix_valid = 1; pif.i_pix_idx = 4'd7;
      tick(0, 0, 0);
      pif.i_pix_valid = 0;
      tick(0, 0, 0);
      chk("t6_new_pixel_valid", 32'(pif.o_pix_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
